// File: rtl/farmway_vehicle_detector_if.sv
// Loop/light inputs and request/status outputs between the farmway detector and its environment.
interface farmway_vehicle_detector_if #(
  parameter int QUEUE_W = 4
);
  logic               loop_raw;
  logic [2:0]         light_farmway;
  logic               sensor;
  logic [QUEUE_W-1:0] queue_count;
  logic               vehicle_pulse;
  logic               fault;

  modport master (
    output loop_raw, light_farmway,
    input  sensor, queue_count, vehicle_pulse, fault
  );

  modport slave (
    input  loop_raw, light_farmway,
    output sensor, queue_count, vehicle_pulse, fault
  );
endinterface

// File: rtl/farmway_vehicle_detector.sv
// Farmway loop front-end: sync + debounce, waiting-vehicle count cleared on green,
// sticky fault on stuck loop or illegal light code; sensor request held while vehicles wait.
module farmway_vehicle_detector #(
  parameter int DEBOUNCE_CYC = 3,
  parameter int QUEUE_W      = 4,
  parameter int TICK_DIV     = 4,
  parameter int STUCK_TICKS  = 20
) (
  input logic                        clk,
  input logic                        rst,
  farmway_vehicle_detector_if.slave  bus
);
  localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);
  localparam int TK_W = $clog2(TICK_DIV + 1);
  localparam int ST_W = $clog2(STUCK_TICKS + 1);

  typedef enum logic [0:0] {IDLE, OCCUPIED} state_t;

  state_t             state_q, state_d;
  logic               s1_q, s1_d, s2_q, s2_d;
  logic [DB_W-1:0]    db_cnt_q, db_cnt_d;
  logic               loop_stable_q, loop_stable_d;
  logic [QUEUE_W-1:0] queue_count_q, queue_count_d;
  logic               vehicle_pulse_q, vehicle_pulse_d;
  logic               sensor_q, sensor_d;
  logic               fault_q, fault_d;
  logic [TK_W-1:0]    tick_cnt_q, tick_cnt_d;
  logic [ST_W-1:0]    stuck_cnt_q, stuck_cnt_d;
  logic               illegal_q, illegal_d;
  logic               arrival, tick, green, legal;

  always_comb begin
    s1_d            = bus.loop_raw;
    s2_d            = s1_q;
    db_cnt_d        = '0;
    loop_stable_d   = loop_stable_q;
    state_d         = state_q;
    arrival         = 1'b0;
    green           = (bus.light_farmway == 3'b001);
    legal           = (bus.light_farmway == 3'b100) || (bus.light_farmway == 3'b010) || green;
    queue_count_d   = queue_count_q;
    tick            = (tick_cnt_q == TK_W'(TICK_DIV - 1));
    tick_cnt_d      = tick ? '0 : tick_cnt_q + 1'b1;
    stuck_cnt_d     = stuck_cnt_q;
    illegal_d       = ~legal;

    // Any cycle where the synchronized level agrees with the accepted level restarts the count.
    if (s2_q != loop_stable_q) begin
      if (db_cnt_q == DB_W'(DEBOUNCE_CYC - 1)) begin
        loop_stable_d = ~loop_stable_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (loop_stable_q) begin
          state_d = OCCUPIED;
          arrival = 1'b1;
        end
      end
      OCCUPIED: begin
        if (!loop_stable_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Green beats a coincident arrival; yellow lets arrivals accumulate.
    if (green) begin
      queue_count_d = '0;
    end else if (arrival && (queue_count_q != {QUEUE_W{1'b1}})) begin
      queue_count_d = queue_count_q + 1'b1;
    end

    if (!loop_stable_q) begin
      stuck_cnt_d = '0;
    end else if (tick && (stuck_cnt_q != ST_W'(STUCK_TICKS))) begin
      stuck_cnt_d = stuck_cnt_q + 1'b1;
    end

    fault_d         = fault_q | (stuck_cnt_d == ST_W'(STUCK_TICKS)) | (illegal_q & ~legal);
    sensor_d        = (queue_count_d != '0) | fault_d;
    vehicle_pulse_d = arrival;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      s1_q            <= 1'b0;
      s2_q            <= 1'b0;
      db_cnt_q        <= '0;
      loop_stable_q   <= 1'b0;
      queue_count_q   <= '0;
      vehicle_pulse_q <= 1'b0;
      sensor_q        <= 1'b0;
      fault_q         <= 1'b0;
      tick_cnt_q      <= '0;
      stuck_cnt_q     <= '0;
      illegal_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      s1_q            <= s1_d;
      s2_q            <= s2_d;
      db_cnt_q        <= db_cnt_d;
      loop_stable_q   <= loop_stable_d;
      queue_count_q   <= queue_count_d;
      vehicle_pulse_q <= vehicle_pulse_d;
      sensor_q        <= sensor_d;
      fault_q         <= fault_d;
      tick_cnt_q      <= tick_cnt_d;
      stuck_cnt_q     <= stuck_cnt_d;
      illegal_q       <= illegal_d;
    end
  end

  assign bus.sensor        = sensor_q;
  assign bus.queue_count   = queue_count_q;
  assign bus.vehicle_pulse = vehicle_pulse_q;
  assign bus.fault         = fault_q;
endmodule

// File: tb/tb_farmway_vehicle_detector.sv
// Bench for farmway_vehicle_detector: arrivals are scoreboarded (expected edge, count, sensor)
// and matched against vehicle_pulse; scenario checks cover reset, glitch, service, saturation and faults.
module tb_farmway_vehicle_detector;
  localparam int QW  = 4;
  localparam int MAX = (1 << QW) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  farmway_vehicle_detector_if #(.QUEUE_W(QW)) bus ();

  farmway_vehicle_detector #(
    .DEBOUNCE_CYC (3),
    .QUEUE_W      (QW),
    .TICK_DIV     (4),
    .STUCK_TICKS  (20)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int cyc;
    int qc;
    int sen;
  } exp_t;

  exp_t sb[$];
  int   cyc     = 0;
  int   n_vec   = 0;
  int   n_err   = 0;
  int   m_cnt   = 0;
  int   m_fault = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Arrival monitor: every observed pulse must match the oldest pending expectation.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (bus.vehicle_pulse === 1'b1) begin
        if (sb.size() == 0) begin
          chk("pulse_unexpected", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("pulse_cyc", cyc, e.cyc);
          chk("pulse_qc", bus.queue_count, e.qc);
          chk("pulse_sensor", bus.sensor, e.sen);
        end
      end
    end
  end

  // Called right after an edge, just before loop_raw rises: pulse lands 6 edges later.
  task automatic push_arrival();
    exp_t e;
    if (bus.light_farmway == 3'b001) m_cnt = 0;
    else if (m_cnt < MAX) m_cnt++;
    e.cyc = cyc + 6;
    e.qc  = m_cnt;
    e.sen = ((m_cnt != 0) || (m_fault != 0)) ? 1 : 0;
    sb.push_back(e);
  endtask

  task automatic arrive(input int hold, input int gap);
    push_arrival();
    bus.loop_raw = 1'b1;
    step(hold);
    bus.loop_raw = 1'b0;
    step(gap);
  endtask

  task automatic reset_dut(input logic loop_v, input logic [2:0] light_v);
    rst = 1'b1;
    bus.loop_raw = loop_v;
    bus.light_farmway = light_v;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("rst_outputs", {bus.sensor, bus.queue_count, bus.vehicle_pulse, bus.fault}, 32'd0);
    end
    rst = 1'b0;
    bus.loop_raw = 1'b0;
    bus.light_farmway = 3'b100;
    m_cnt = 0;
    m_fault = 0;
    step(1);
    chk("post_rst_outputs", {bus.sensor, bus.queue_count, bus.vehicle_pulse, bus.fault}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int c;
    reset_dut(1'b1, 3'b011);
    step(8);

    // Glitch shorter than the debounce window.
    bus.loop_raw = 1'b1;
    step(2);
    bus.loop_raw = 1'b0;
    step(10);
    chk("glitch_qc", bus.queue_count, 32'd0);
    chk("glitch_sensor", bus.sensor, 32'd0);

    // Clean arrival with exact latency.
    c = cyc;
    push_arrival();
    bus.loop_raw = 1'b1;
    step(5);
    chk("arr_early_qc", bus.queue_count, 32'd0);
    step(1);
    chk("arr_qc", bus.queue_count, 32'd1);
    chk("arr_sensor", bus.sensor, 32'd1);
    chk("arr_pulse", bus.vehicle_pulse, 32'd1);
    chk("arr_edge", cyc - c, 32'd6);
    step(1);
    chk("arr_pulse_end", bus.vehicle_pulse, 32'd0);
    step(3);
    bus.loop_raw = 1'b0;
    step(8);
    chk("fall_qc", bus.queue_count, 32'd1);

    // Service on green, then an arrival during green.
    arrive(6, 8);
    arrive(6, 8);
    chk("three_qc", bus.queue_count, 32'd3);
    bus.light_farmway = 3'b001;
    m_cnt = 0;
    step(1);
    chk("green_qc", bus.queue_count, 32'd0);
    chk("green_sensor", bus.sensor, 32'd0);
    arrive(6, 8);
    chk("green_arr_qc", bus.queue_count, 32'd0);
    bus.light_farmway = 3'b010;
    arrive(6, 8);
    chk("yellow_arr_qc", bus.queue_count, 32'd1);
    bus.light_farmway = 3'b100;
    step(1);

    // Saturation.
    for (int i = 0; i < 17; i++) arrive(6, 8);
    chk("sat_qc", bus.queue_count, MAX);
    chk("sat_sensor", bus.sensor, 32'd1);
    step(5);
    chk("sat_hold_qc", bus.queue_count, MAX);
    bus.light_farmway = 3'b001;
    m_cnt = 0;
    step(1);
    bus.light_farmway = 3'b100;
    step(1);
    chk("clear_qc", bus.queue_count, 32'd0);

    // Illegal light code: one cycle tolerated, two consecutive fault.
    bus.light_farmway = 3'b011;
    step(1);
    bus.light_farmway = 3'b100;
    step(3);
    chk("ill1_fault", bus.fault, 32'd0);
    chk("ill1_sensor", bus.sensor, 32'd0);
    bus.light_farmway = 3'b011;
    step(1);
    chk("ill2_first_fault", bus.fault, 32'd0);
    step(1);
    chk("ill2_fault", bus.fault, 32'd1);
    chk("ill2_sensor", bus.sensor, 32'd1);
    m_fault = 1;
    bus.light_farmway = 3'b100;
    step(3);
    chk("ill_sticky", bus.fault, 32'd1);
    reset_dut(1'b0, 3'b100);
    step(8);

    // Stuck loop: fault lands between 77 and 80 cycles after loop_stable rises.
    c = cyc;
    push_arrival();
    bus.loop_raw = 1'b1;
    step(81);
    chk("stuck_early", bus.fault, 32'd0);
    step(4);
    chk("stuck_fault", bus.fault, 32'd1);
    m_fault = 1;
    step(5);
    bus.light_farmway = 3'b001;
    m_cnt = 0;
    step(1);
    chk("stuck_green_qc", bus.queue_count, 32'd0);
    chk("stuck_green_sensor", bus.sensor, 32'd1);
    bus.loop_raw = 1'b0;
    step(10);
    chk("stuck_rel_sensor", bus.sensor, 32'd1);
    chk("stuck_rel_fault", bus.fault, 32'd1);
    bus.light_farmway = 3'b100;
    reset_dut(1'b0, 3'b100);

    step(10);
    chk("sb_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
